data_memory_bytelane: RTL and testbench

- Next-generation data memory for the single-cycle/pipelined CPU datapath.
- Parametrised depth, byte-addressed, with byte/half/word load-store modes, sign/zero-extended loads and registered read data.
- Uses a valid/ready request and a one-cycle response pulse.
- After reset, a sequential init walk replaces the one-shot array clear.
- Misaligned and out-of-range accesses are flagged.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_lane_align.sv | 53 +++++
 rtl/data_memory_bytelane.sv | 130 +++++++++++++
 tb/tb_data_memory_bytelane.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and widths for the byte-lane data memory.
package dmem_pkg;
  localparam int DATA_W    = 32;
  localparam int NUM_LANES = DATA_W / 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;
endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: merges store data into a word and extracts/extends load data.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] wdata,
  input  size_e             size,
  input  logic [1:0]        off,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] st_word,
  output logic [DATA_W-1:0] ld_data
);

  logic [NUM_LANES-1:0] be;
  logic [DATA_W-1:0]    rep;
  logic [DATA_W-1:0]    shifted;
  logic                 sx;

  // Store path: replicate the right-aligned data across lanes, then pick lanes by mask.
  always_comb begin
    be  = '0;
    rep = wdata;
    unique case (size)
      SZ_BYTE: begin be = 4'b0001 << off; rep = {4{wdata[7:0]}};  end
      SZ_HALF: begin be = 4'b0011 << off; rep = {2{wdata[15:0]}}; end
      SZ_WORD: begin be = 4'b1111;        rep = wdata;            end
      default: begin be = '0;             rep = wdata;            end
    endcase
    st_word = old_word;
    for (int i = 0; i < NUM_LANES; i++)
      if (be[i]) st_word[i*8 +: 8] = rep[i*8 +: 8];
  end

  // Load path: shift the addressed lane(s) down to bit 0 and extend.
  always_comb begin
    shifted = old_word >> {off, 3'b000};
    sx      = 1'b0;
    ld_data = '0;
    unique case (size)
      SZ_BYTE: begin
        sx      = ~is_unsigned & shifted[7];
        ld_data = {{24{sx}}, shifted[7:0]};
      end
      SZ_HALF: begin
        sx      = ~is_unsigned & shifted[15];
        ld_data = {{16{sx}}, shifted[15:0]};
      end
      SZ_WORD: ld_data = old_word;
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_bytelane.sv
// Byte-addressed data memory with init walk, sub-word access and a one-cycle response.
module data_memory_bytelane
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 200,
  parameter int          ADDR_W    = 32,
  parameter int          PRE_A_IDX = 2,
  parameter logic [31:0] PRE_A_VAL = 32'd100,
  parameter int          PRE_B_IDX = 3,
  parameter logic [31:0] PRE_B_VAL = 32'd200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WIDX_W = ADDR_W - 2;
  localparam logic [WIDX_W-1:0] DEPTH_W = WIDX_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  init_cnt_q, init_cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [WIDX_W-1:0] widx;
  logic [1:0]        off;
  logic [AW-1:0]     midx;
  logic              in_range, err, acc;
  size_e             size;
  logic [DATA_W-1:0] rd_word, st_word, ld_data;

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] init_val;

  assign req_ready = (state_q == ST_READY);
  assign widx      = addr[ADDR_W-1:2];
  assign off       = addr[1:0];
  assign midx      = widx[AW-1:0];
  assign size      = size_e'(req_size);
  assign in_range  = (widx < DEPTH_W);
  assign rd_word   = in_range ? mem_q[midx] : '0;
  assign acc       = req_valid && req_ready;

  dmem_lane_align u_align (
    .old_word    (rd_word),
    .wdata       (wdata),
    .size        (size),
    .off         (off),
    .is_unsigned (req_unsigned),
    .st_word     (st_word),
    .ld_data     (ld_data)
  );

  // Access legality: reserved size, misalignment, or word index past the array.
  always_comb begin
    err = 1'b0;
    if (size == SZ_RSVD)                  err = 1'b1;
    if (size == SZ_HALF && off[0])        err = 1'b1;
    if (size == SZ_WORD && off != 2'b00)  err = 1'b1;
    if (!in_range)                        err = 1'b1;
  end

  // Next-state: init walk, then one accepted request per cycle with a registered response.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    rsp_valid_d = acc;
    rsp_err_d   = acc && err;
    rsp_rdata_d = (acc && !err && !req_write) ? ld_data : '0;
    init_val    = '0;
    if (init_cnt_q == CNT_W'(PRE_A_IDX))      init_val = PRE_A_VAL;
    else if (init_cnt_q == CNT_W'(PRE_B_IDX)) init_val = PRE_B_VAL;
    mem_we    = 1'b0;
    mem_waddr = midx;
    mem_wdata = st_word;
    if (state_q == ST_INIT) begin
      mem_we     = 1'b1;
      mem_waddr  = init_cnt_q[AW-1:0];
      mem_wdata  = init_val;
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == CNT_W'(DEPTH - 1)) state_d = ST_READY;
    end else if (acc && req_write && !err) begin
      mem_we = 1'b1;
    end
    if (rst) mem_we = 1'b0;
  end

  // Control and response registers; reset drops any in-flight response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Single write port shared by the init walk and stores.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Scoreboard bench for data_memory_bytelane at DEPTH=16.
module tb_data_memory_bytelane;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] addr, wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  typedef struct {
    string       nm;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  data_memory_bytelane #(.DEPTH(16), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .addr(addr), .wdata(wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Monitor: pop and compare whenever a response pulse is present.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rsp_valid === 1'b1) begin
          n_cmp++;
          if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_rsp: got err=%0b rdata=%h, none expected", rsp_err, rsp_rdata);
          end else begin
            e = q.pop_front();
            if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin
              n_bad++;
              $display("FAIL %s: got err=%0b rdata=%h, want err=%0b rdata=%h",
                       e.nm, rsp_err, rsp_rdata, e.err, e.rdata);
            end
          end
        end else if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL idle_zero: valid=%b err=%b rdata=%h, want 0/0/0", rsp_valid, rsp_err, rsp_rdata);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Drive one request for one edge and queue its expected response.
  task automatic issue(input string nm, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic xerr, input logic [31:0] xd);
    exp_t e;
    e.nm = nm; e.err = xerr; e.rdata = xd;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    addr = a; wdata = wd;
    q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: req_ready=%b after %0d cycles, want 1", nm, req_ready, n);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    chk("reset_ready", {31'b0, req_ready}, 32'd0);
    chk("reset_valid", {31'b0, rsp_valid}, 32'd0);

    // Release reset with a store held during INIT; it must be ignored.
    rst = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; addr = 32'd0; wdata = 32'hFFFF_FFFF;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      chk($sformatf("init_ready_edge%0d", k), {31'b0, req_ready}, (k == 16) ? 32'd1 : 32'd0);
    end
    req_valid = 1'b0;

    // Preloaded words and the ignored store.
    issue("ld_pre_a",   0, 2'd2, 0, 32'd8,  0, 0, 32'd100);
    issue("ld_pre_b",   0, 2'd2, 0, 32'd12, 0, 0, 32'd200);
    issue("ld_addr0",   0, 2'd2, 0, 32'd0,  0, 0, 32'd0);

    // Sub-word stores and loads.
    issue("st_w4",      1, 2'd2, 0, 32'd4,  32'h1122_3344, 0, 32'd0);
    issue("st_b6",      1, 2'd0, 0, 32'd6,  32'h0000_00AB, 0, 32'd0);
    issue("ld_w4",      0, 2'd2, 0, 32'd4,  0, 0, 32'h11AB_3344);
    issue("ld_b6_s",    0, 2'd0, 0, 32'd6,  0, 0, 32'hFFFF_FFAB);
    issue("ld_b6_u",    0, 2'd0, 1, 32'd6,  0, 0, 32'h0000_00AB);
    issue("ld_h6_s",    0, 2'd1, 0, 32'd6,  0, 0, 32'h0000_11AB);
    issue("ld_b7_s",    0, 2'd0, 0, 32'd7,  0, 0, 32'h0000_0011);
    issue("st_h20",     1, 2'd1, 0, 32'd20, 32'h0000_8001, 0, 32'd0);
    issue("ld_h20_s",   0, 2'd1, 0, 32'd20, 0, 0, 32'hFFFF_8001);
    issue("ld_h20_u",   0, 2'd1, 1, 32'd20, 0, 0, 32'h0000_8001);
    issue("ld_w20",     0, 2'd2, 0, 32'd20, 0, 0, 32'h0000_8001);

    // Errors: memory at addr 0 must stay untouched.
    issue("err_h5",     0, 2'd1, 0, 32'd5,  0, 1, 32'd0);
    issue("err_st_w2",  1, 2'd2, 0, 32'd2,  32'hFFFF_FFFF, 1, 32'd0);
    issue("err_rsvd",   1, 2'd3, 0, 32'd0,  32'hFFFF_FFFF, 1, 32'd0);
    issue("err_w64",    0, 2'd2, 0, 32'd64, 0, 1, 32'd0);
    issue("err_alias",  1, 2'd2, 0, 32'h4000_0000, 32'hFFFF_FFFF, 1, 32'd0);
    issue("ld_addr0_2", 0, 2'd2, 0, 32'd0,  0, 0, 32'd0);

    // Back-to-back store then load to the same word.
    issue("st_w28",     1, 2'd2, 0, 32'd28, 32'hDEAD_BEEF, 0, 32'd0);
    issue("ld_w28",     0, 2'd2, 0, 32'd28, 0, 0, 32'hDEAD_BEEF);
    repeat (2) @(posedge clk);
    #1;
    chk("drain_before_reset", q.size(), 32'd0);

    // Reset arrives on the same edge as a load: no response, init walk repeats.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; addr = 32'd8; rst = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("midreset_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ready("reinit_timeout");
    issue("reinit_w4",  0, 2'd2, 0, 32'd4,  0, 0, 32'd0);
    issue("reinit_w8",  0, 2'd2, 0, 32'd8,  0, 0, 32'd100);
    issue("reinit_w28", 0, 2'd2, 0, 32'd28, 0, 0, 32'd0);
    issue("reinit_w20", 0, 2'd2, 0, 32'd20, 0, 0, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("final_drain", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
